// File: rtl/io_debug_port.sv
// io_debug_port: I/O-space debug console port.
// CPU writes to DATA_PORT push one byte (byte access) or two bytes (word
// access, low byte first) into a small FIFO. STAT_PORT reads back the fill
// level plus a sticky overflow flag. Writing 1 to bit 0 of STAT_PORT clears
// that flag. The FIFO drains through a valid/ready byte stream.
//
// Stream handshake: tx_valid is high whenever the FIFO holds at least one
// byte, and tx_data is the head byte. A byte transfers on every posedge where
// tx_valid && tx_ready. While tx_ready is low, tx_valid and tx_data hold
// steady. tx_valid never depends on tx_ready.
module io_debug_port #(
   parameter logic [15:0] DATA_PORT  = 16'h00B7,
   parameter logic [15:0] STAT_PORT  = 16'h00B8,
   parameter int          DEPTH_LOG2 = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [19:0] addr,
   input  logic [15:0] wr_data,
   input  logic        we,
   input  logic        m_io,
   input  logic        byte_m,
   output logic [15:0] io_rd_data,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CW    = DEPTH_LOG2 + 1;

   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [CW-1:0]         count;
   logic                  ovf;
   logic [15:0]           data_reg;
   logic                  wr_d_q;
   logic                  wr_s_q;

   logic                  sel_d, sel_s, wr_d, wr_s;
   logic                  push, clr, pop;
   logic [CW-1:0]         need, room, pushed;
   logic                  push_ok, drop;
   logic                  empty, full;
   logic [4:0]            cnt5;

   // Only the low 16 address bits take part in I/O decode.
   logic                  unused_addr_hi;
   assign unused_addr_hi = ^addr[19:16];

   // Decode, first-cycle edge detect and room check for the push.
   always_comb begin
      sel_d   = m_io & (addr[15:0] == DATA_PORT);
      sel_s   = m_io & (addr[15:0] == STAT_PORT);
      wr_d    = sel_d & ~we;
      wr_s    = sel_s & ~we;
      push    = wr_d & ~wr_d_q;
      clr     = wr_s & ~wr_s_q;
      pop     = tx_valid & tx_ready;
      need    = byte_m ? CW'(1) : CW'(2);
      // A same-cycle pop frees one slot before the push is judged.
      room    = CW'(DEPTH) - count + CW'(pop);
      push_ok = push & (room >= need);
      drop    = push & ~push_ok;
      pushed  = push_ok ? need : '0;
      empty   = (count == '0);
      full    = (count == CW'(DEPTH));
      cnt5    = 5'(count);
   end

   // Control state: edge-detect flops, pointers, count, overflow, shadow data.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_d_q   <= 1'b0;
         wr_s_q   <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         ovf      <= 1'b0;
         data_reg <= '0;
      end else begin
         wr_d_q <= wr_d;
         wr_s_q <= wr_s;
         if (push_ok)
            wr_ptr <= wr_ptr + DEPTH_LOG2'(need);
         if (pop)
            rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
         count <= count + pushed - CW'(pop);
         // The shadow copy follows every new data write, even a dropped one.
         if (push)
            data_reg <= byte_m ? {data_reg[15:8], wr_data[7:0]} : wr_data;
         // An overflow in the same cycle as a clear wins.
         if (drop)
            ovf <= 1'b1;
         else if (clr && wr_data[0])
            ovf <= 1'b0;
      end
   end

   // FIFO storage, deliberately not reset; a word fills two slots at once.
   always_ff @(posedge clk) begin
      if (rst && push_ok) begin
         mem[wr_ptr] <= wr_data[7:0];
         if (!byte_m)
            mem[wr_ptr + DEPTH_LOG2'(1)] <= wr_data[15:8];
      end
   end

   // Zero-wait-state read mux toward the CPU.
   always_comb begin
      io_rd_data = 16'h0000;
      if (sel_d)
         io_rd_data = data_reg;
      else if (sel_s)
         io_rd_data = {8'h00, ovf, empty, full, cnt5};
   end

   assign tx_valid = ~empty;
   assign tx_data  = mem[rd_ptr];

endmodule

// File: tb/tb_io_debug_port.sv
// Directed bench for io_debug_port: CPU-side driver tasks, a byte-stream
// monitor backed by an expected-byte queue, and a single summary line.
module tb_io_debug_port;

   logic        clk = 1'b0;
   logic        rst;
   logic [19:0] addr;
   logic [15:0] wr_data;
   logic        we;
   logic        m_io;
   logic        byte_m;
   logic [15:0] io_rd_data;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   logic [7:0]  exp_q[$];
   int          n_vec = 0;
   int          n_err = 0;

   io_debug_port dut (
      .clk        (clk),
      .rst        (rst),
      .addr       (addr),
      .wr_data    (wr_data),
      .we         (we),
      .m_io       (m_io),
      .byte_m     (byte_m),
      .io_rd_data (io_rd_data),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready)
   );

   // Clock and watchdog.
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 16'h%h, expected 16'h%h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every byte accepted by the consumer must match the queue head.
   always @(negedge clk) begin
      if (rst && tx_valid && tx_ready) begin
         if (exp_q.size() == 0)
            check("sb_unexpected_pop", 16'(exp_q.size()), 16'd1);
         else
            check("tx_data", {8'h00, tx_data}, {8'h00, exp_q.pop_front()});
      end
   end

   // Driver tasks.
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic io_write(input logic [15:0] a, input logic [15:0] d,
                           input logic bm, input int hold);
      addr    = {4'h0, a};
      wr_data = d;
      byte_m  = bm;
      m_io    = 1'b1;
      we      = 1'b0;
      cyc(hold);
      we      = 1'b1;
      m_io    = 1'b0;
      cyc(1);
   endtask

   task automatic io_read(input logic [15:0] a, input string tag, input logic [15:0] exp);
      addr = {4'h0, a};
      m_io = 1'b1;
      we   = 1'b1;
      #1;
      check(tag, io_rd_data, exp);
      m_io = 1'b0;
   endtask

   task automatic drain(input string tag);
      int budget;
      budget   = 40;
      tx_ready = 1'b1;
      while (tx_valid && budget > 0) begin
         cyc(1);
         budget--;
      end
      tx_ready = 1'b0;
      if (budget == 0)
         check({tag, "_timeout"}, {15'd0, tx_valid}, 16'd0);
      check({tag, "_q_left"}, 16'(exp_q.size()), 16'd0);
   endtask

   initial begin
      rst      = 1'b0;
      addr     = '0;
      wr_data  = '0;
      we       = 1'b1;
      m_io     = 1'b0;
      byte_m   = 1'b1;
      tx_ready = 1'b0;
      cyc(3);
      rst = 1'b1;
      cyc(1);

      // Reset state.
      check("rst_tx_valid", {15'd0, tx_valid}, 16'd0);
      io_read(16'h00B8, "rst_status", 16'h0040);
      io_read(16'h00B7, "rst_data", 16'h0000);

      // Byte write held 3 cycles pushes exactly once.
      io_write(16'h00B7, 16'h1241, 1'b1, 3);
      exp_q.push_back(8'h41);
      check("t1_tx_valid", {15'd0, tx_valid}, 16'd1);
      check("t1_tx_data", {8'h00, tx_data}, 16'h0041);
      io_read(16'h00B8, "t1_status", 16'h0001);
      io_read(16'h00B7, "t1_data", 16'h0041);
      drain("t1_drain");

      // Word write drains low byte then high byte.
      tx_ready = 1'b1;
      exp_q.push_back(8'hEF);
      exp_q.push_back(8'hBE);
      io_write(16'h00B7, 16'hBEEF, 1'b0, 1);
      cyc(1);
      check("t2_tx_valid", {15'd0, tx_valid}, 16'd0);
      check("t2_q_left", 16'(exp_q.size()), 16'd0);
      tx_ready = 1'b0;
      io_read(16'h00B7, "t2_data", 16'hBEEF);

      // Fill to 16, overflow on the 17th, then clear the flag.
      for (int i = 0; i < 16; i++) begin
         io_write(16'h00B7, 16'h0010 + 16'(i), 1'b1, 1);
         exp_q.push_back(8'h10 + 8'(i));
      end
      io_read(16'h00B8, "t3_full", 16'h0030);
      io_write(16'h00B7, 16'h00AA, 1'b1, 1);
      io_read(16'h00B8, "t3_ovf", 16'h00B0);
      io_read(16'h00B7, "t3_shadow", 16'hBEAA);
      io_write(16'h00B8, 16'h00FE, 1'b0, 1);
      io_read(16'h00B8, "t3_clr_bit0_low", 16'h00B0);
      io_write(16'h00B8, 16'h0001, 1'b0, 1);
      io_read(16'h00B8, "t3_cleared", 16'h0030);

      // Full FIFO, pop in the same cycle as a byte write: accepted.
      addr = 20'h000B7; wr_data = 16'h0055; byte_m = 1'b1; m_io = 1'b1; we = 1'b0;
      tx_ready = 1'b1;
      cyc(1);
      exp_q.push_back(8'h55);
      we = 1'b1; m_io = 1'b0; tx_ready = 1'b0;
      cyc(1);
      io_read(16'h00B8, "t4_full_pop_byte", 16'h0030);

      // Full FIFO, pop in the same cycle as a word write: dropped.
      addr = 20'h000B7; wr_data = 16'h6677; byte_m = 1'b0; m_io = 1'b1; we = 1'b0;
      tx_ready = 1'b1;
      cyc(1);
      we = 1'b1; m_io = 1'b0; tx_ready = 1'b0;
      cyc(1);
      io_read(16'h00B8, "t4_full_pop_word", 16'h008F);
      io_write(16'h00B8, 16'h0001, 1'b0, 1);
      io_read(16'h00B8, "t4_clr", 16'h000F);

      // 15 bytes queued, word write needs 2 slots: dropped.
      io_write(16'h00B7, 16'h1234, 1'b0, 1);
      io_read(16'h00B8, "t4_15_word", 16'h008F);
      io_read(16'h00B7, "t4_shadow_word", 16'h1234);
      io_write(16'h00B8, 16'h0001, 1'b0, 1);
      drain("t4_drain");
      io_read(16'h00B8, "t4_empty", 16'h0040);

      // Memory-space write to a matching address is ignored.
      addr = 20'h000B7; wr_data = 16'h0077; byte_m = 1'b1; m_io = 1'b0; we = 1'b0;
      cyc(2);
      we = 1'b1;
      cyc(1);
      check("t5_mem_no_push", {15'd0, tx_valid}, 16'd0);
      #1;
      check("t5_mem_read", io_rd_data, 16'h0000);
      io_read(16'h00B9, "t5_other_port", 16'h0000);
      io_read(16'h00B8, "t5_status", 16'h0040);

      // Reset with 5 bytes queued flushes everything.
      for (int i = 1; i <= 5; i++)
         io_write(16'h00B7, 16'(i), 1'b1, 1);
      io_read(16'h00B8, "t6_five", 16'h0005);
      rst = 1'b0;
      cyc(1);
      rst = 1'b1;
      check("t6_tx_valid", {15'd0, tx_valid}, 16'd0);
      io_read(16'h00B8, "t6_status", 16'h0040);
      io_read(16'h00B7, "t6_data", 16'h0000);

      // A write held across reset release pushes once afterwards.
      addr = 20'h000B7; wr_data = 16'h00C3; byte_m = 1'b1; m_io = 1'b1; we = 1'b0;
      rst = 1'b0;
      cyc(1);
      rst = 1'b1;
      cyc(2);
      we = 1'b1; m_io = 1'b0;
      cyc(1);
      exp_q.push_back(8'hC3);
      io_read(16'h00B8, "t6_held_once", 16'h0001);
      drain("t6_drain");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
